// File: rtl/regfile_bypass_pkg.sv
// Shared constants and types for the AArch64 integer register file.
// X31 is the architectural zero register and has no storage.
package regfile_pkg;

    localparam int DATA_W = 64;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t ZERO_REG = 5'd31;

endpackage

// File: rtl/regfile_bypass_if.sv
// Write-back port and two ID-stage read ports of the register file.
// The master drives indices and write data; the slave returns the operands.
interface regfile_bypass_if;
    import regfile_pkg::*;

    logic     RegWrite;
    reg_idx_t WriteRegister;
    word_t    WriteData;
    reg_idx_t ReadRegister1;
    reg_idx_t ReadRegister2;
    word_t    ReadData1;
    word_t    ReadData2;

    modport master (
        output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/regfile_bypass_mux.sv
// Structural 1-bit mux primitives: 2:1 leaf, 8:1 tree and the 32:1 read tree
// (four 8:1 trees on sel[2:0] followed by a 4:1 stage on sel[4:3]).
module mux_2_1 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    assign y = sel ? b : a;
endmodule

module mux_8_1 (
    input  logic [7:0] in,
    input  logic [2:0] sel,
    output logic       y
);
    logic [3:0] l0_s;
    logic [1:0] l1_s;

    for (genvar i = 0; i < 4; i++) begin : g_l0
        mux_2_1 u_m (.a(in[2*i]), .b(in[2*i+1]), .sel(sel[0]), .y(l0_s[i]));
    end
    for (genvar i = 0; i < 2; i++) begin : g_l1
        mux_2_1 u_m (.a(l0_s[2*i]), .b(l0_s[2*i+1]), .sel(sel[1]), .y(l1_s[i]));
    end
    mux_2_1 u_l2 (.a(l1_s[0]), .b(l1_s[1]), .sel(sel[2]), .y(y));
endmodule

module mux_32_1 (
    input  logic [31:0] in,
    input  logic [4:0]  sel,
    output logic        y
);
    logic [3:0] oct_s;
    logic [1:0] pair_s;

    for (genvar g = 0; g < 4; g++) begin : g_oct
        mux_8_1 u_m8 (.in(in[8*g +: 8]), .sel(sel[2:0]), .y(oct_s[g]));
    end
    mux_2_1 u_p0  (.a(oct_s[0]),  .b(oct_s[1]),  .sel(sel[3]), .y(pair_s[0]));
    mux_2_1 u_p1  (.a(oct_s[2]),  .b(oct_s[3]),  .sel(sel[3]), .y(pair_s[1]));
    mux_2_1 u_fin (.a(pair_s[0]), .b(pair_s[1]), .sel(sel[4]), .y(y));
endmodule

// File: rtl/regfile_bypass.sv
// 32x64 register file with X31 hardwired to zero, two combinational read
// ports and a same-cycle write-to-read bypass from the WB stage.
module regfile_bypass
    import regfile_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    regfile_bypass_if.slave        bus
);

    word_t              regs_r [NREGS-1];
    logic [NREGS-2:0]   we_s;
    logic [NREGS-1:0]   col_s  [DATA_W];
    word_t              tree1_s;
    word_t              tree2_s;
    logic               byp1_s;
    logic               byp2_s;

    // Write-enable decoder; index 31 never decodes, so zero-register writes vanish
    always_comb begin
        we_s = '0;
        for (int r = 0; r < NREGS - 1; r++) begin
            we_s[r] = bus.RegWrite && (bus.WriteRegister == reg_idx_t'(r))
                      && (bus.WriteRegister != ZERO_REG);
        end
    end

    for (genvar r = 0; r < NREGS - 1; r++) begin : g_store
        // Architectural register X<r>, cleared asynchronously by reset
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                regs_r[r] <= '0;
            end else if (we_s[r]) begin
                regs_r[r] <= bus.WriteData;
            end
        end
    end

    // Transpose storage into per-bit mux columns; column entry 31 is the zero register
    always_comb begin
        for (int b = 0; b < DATA_W; b++) begin
            col_s[b] = '0;
            for (int r = 0; r < NREGS - 1; r++) begin
                col_s[b][r] = regs_r[r][b];
            end
        end
    end

    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
        mux_32_1 u_rd1 (.in(col_s[b]), .sel(bus.ReadRegister1), .y(tree1_s[b]));
        mux_32_1 u_rd2 (.in(col_s[b]), .sel(bus.ReadRegister2), .y(tree2_s[b]));
    end

    // Bypass compare runs beside the mux trees
    always_comb begin
        byp1_s = bus.RegWrite && (bus.WriteRegister == bus.ReadRegister1)
                 && (bus.WriteRegister != ZERO_REG);
        byp2_s = bus.RegWrite && (bus.WriteRegister == bus.ReadRegister2)
                 && (bus.WriteRegister != ZERO_REG);
    end

    // Final operand select: reset, then zero register, then bypass, then storage
    always_comb begin
        if (!reset_n || (bus.ReadRegister1 == ZERO_REG)) begin
            bus.ReadData1 = '0;
        end else if (byp1_s) begin
            bus.ReadData1 = bus.WriteData;
        end else begin
            bus.ReadData1 = tree1_s;
        end

        if (!reset_n || (bus.ReadRegister2 == ZERO_REG)) begin
            bus.ReadData2 = '0;
        end else if (byp2_s) begin
            bus.ReadData2 = bus.WriteData;
        end else begin
            bus.ReadData2 = tree2_s;
        end
    end

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed test of regfile_bypass: stimulus pushes expected operands into a
// scoreboard queue, a monitor process pops and compares each sample.
module tb_regfile_bypass;
    import regfile_pkg::*;

    typedef struct {
        string name;
        word_t e1;
        word_t e2;
    } exp_t;

    logic clk;
    logic reset_n;
    regfile_bypass_if bus ();

    regfile_bypass dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t  sb_q [$];
    event  sample_ev;
    int    n_checks;
    int    n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: each sample event presents one output pair to compare
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_underflow: sample with no expected entry");
            end else begin
                e = sb_q.pop_front();
                n_checks++;
                if (bus.ReadData1 !== e.e1) begin
                    n_errors++;
                    $display("FAIL %s rd1: got %h want %h", e.name, bus.ReadData1, e.e1);
                end
                n_checks++;
                if (bus.ReadData2 !== e.e2) begin
                    n_errors++;
                    $display("FAIL %s rd2: got %h want %h", e.name, bus.ReadData2, e.e2);
                end
            end
        end
    end

    task automatic expect_rd(input string name, input word_t e1, input word_t e2);
        exp_t e;
        e.name = name;
        e.e1   = e1;
        e.e2   = e2;
        #1;
        sb_q.push_back(e);
        ->sample_ev;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_wr(input logic we, input reg_idx_t wr, input word_t wd);
        bus.RegWrite      = we;
        bus.WriteRegister = wr;
        bus.WriteData     = wd;
    endtask

    task automatic set_rd(input reg_idx_t r1, input reg_idx_t r2);
        bus.ReadRegister1 = r1;
        bus.ReadRegister2 = r2;
    endtask

    initial begin
        word_t base;
        base     = 64'h1111_0000_0000_0000;
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        set_wr(1'b0, 5'd0, 64'd0);
        set_rd(5'd0, 5'd5);
        #3;
        expect_rd("reset_idle", 64'd0, 64'd0);
        set_wr(1'b1, 5'd5, 64'h0123_4567_89AB_CDEF);
        set_rd(5'd5, 5'd5);
        expect_rd("reset_no_bypass", 64'd0, 64'd0);
        set_wr(1'b0, 5'd0, 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Reset clears storage immediately, between edges
        set_wr(1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001);
        tick();
        set_wr(1'b0, 5'd0, 64'd0);
        set_rd(5'd5, 5'd5);
        expect_rd("x5_written", 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001);
        reset_n = 1'b0;
        expect_rd("x5_async_clear", 64'd0, 64'd0);
        reset_n = 1'b1;
        expect_rd("x5_after_release", 64'd0, 64'd0);
        tick();
        expect_rd("x5_stays_zero", 64'd0, 64'd0);

        // Fill X0..X30; port 1 shows the bypass during each write
        for (int i = 0; i < 31; i++) begin
            set_wr(1'b1, reg_idx_t'(i), base + 64'(i));
            set_rd(reg_idx_t'(i), 5'd31);
            expect_rd($sformatf("fill_bypass_%0d", i), base + 64'(i), 64'd0);
            tick();
        end
        set_wr(1'b0, 5'd0, 64'd0);
        for (int i = 0; i < 31; i++) begin
            set_rd(reg_idx_t'(i), reg_idx_t'(30 - i));
            expect_rd($sformatf("readback_%0d", i), base + 64'(i), base + 64'(30 - i));
        end

        // Zero register ignores writes and never bypasses
        set_wr(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        set_rd(5'd31, 5'd31);
        expect_rd("x31_before_edge", 64'd0, 64'd0);
        tick();
        expect_rd("x31_after_edge", 64'd0, 64'd0);
        set_wr(1'b0, 5'd0, 64'd0);
        for (int i = 0; i < 31; i += 2) begin
            set_rd(reg_idx_t'(i), reg_idx_t'(i + 1));
            expect_rd($sformatf("x31_unchanged_%0d", i), base + 64'(i),
                      (i + 1 == 31) ? 64'd0 : base + 64'(i + 1));
        end

        // Bypass on both ports to the same index
        set_wr(1'b1, 5'd7, 64'h0000_0000_0000_AAAA);
        tick();
        set_wr(1'b0, 5'd7, 64'h0000_0000_0000_5555);
        set_rd(5'd7, 5'd7);
        expect_rd("x7_no_we_stored", 64'h0000_0000_0000_AAAA, 64'h0000_0000_0000_AAAA);
        set_wr(1'b1, 5'd7, 64'h0000_0000_0000_5555);
        expect_rd("x7_bypass", 64'h0000_0000_0000_5555, 64'h0000_0000_0000_5555);
        tick();
        set_wr(1'b0, 5'd7, 64'h0000_0000_0000_1111);
        expect_rd("x7_committed", 64'h0000_0000_0000_5555, 64'h0000_0000_0000_5555);

        // Disabled write holds across several edges
        set_wr(1'b0, 5'd3, 64'h0000_0000_0000_1234);
        set_rd(5'd3, 5'd3);
        for (int k = 0; k < 3; k++) begin
            expect_rd($sformatf("x3_hold_%0d", k), base + 64'd3, base + 64'd3);
            tick();
        end
        expect_rd("x3_hold_final", base + 64'd3, base + 64'd3);

        // Back-to-back writes to one index: last edge wins
        set_wr(1'b1, 5'd10, 64'h0000_0000_0000_0001);
        set_rd(5'd10, 5'd11);
        tick();
        set_wr(1'b1, 5'd10, 64'h0000_0000_0000_0002);
        expect_rd("x10_b2b_bypass", 64'h0000_0000_0000_0002, base + 64'd11);
        tick();
        set_wr(1'b0, 5'd0, 64'd0);
        expect_rd("x10_b2b_final", 64'h0000_0000_0000_0002, base + 64'd11);

        // Reset asserted across a pending write discards it
        set_wr(1'b1, 5'd9, 64'h0000_0000_0000_0077);
        set_rd(5'd9, 5'd3);
        expect_rd("x9_bypass_pre_reset", 64'h0000_0000_0000_0077, base + 64'd3);
        reset_n = 1'b0;
        expect_rd("x9_during_reset", 64'd0, 64'd0);
        tick();
        expect_rd("x9_reset_edge", 64'd0, 64'd0);
        set_wr(1'b0, 5'd0, 64'd0);
        reset_n = 1'b1;
        expect_rd("x9_after_release", 64'd0, 64'd0);
        set_wr(1'b1, 5'd9, 64'h0000_0000_0000_0099);
        tick();
        set_wr(1'b0, 5'd0, 64'd0);
        expect_rd("x9_first_write", 64'h0000_0000_0000_0099, 64'd0);

        #5;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_drain: got %0d entries left want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
